logic_op_sequencer: RTL
=======================

# logic_op_sequencer

Command sequencer that sits directly upstream of the 4-bit logic unit (`taskrun`). It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the logic unit's `a`/`b`/`opcode` inputs, captures the unit's combinational 5-bit `result`, and presents it downstream with a valid/ready handshake and a completed-operation counter.

## Interface
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  command present.
- `in_ready`  output  1  FIFO can accept; equals (fifo_count < DEPTH).
- `in_a`, `in_b`  input  4 each  operands.
- `in_op`  input  2  opcode (00/01 AND, 10/11 OR).
- `alu_a`, `alu_b`  output  4 each  registered drive to logic unit `a`, `b`.
- `alu_op`  output  2  registered drive to logic unit `opcode`.
- `alu_result`  input  5  logic unit `result`; combinational from `alu_*`.
- `out_valid`  output  1  `out_result` holds a captured result.
- `out_ready`  input  1  downstream accepts.
- `out_result`  output  5  captured result.
- `out_op`  output  2  opcode that produced `out_result`.
- `op_count`  output  8  completed output handshakes, modulo 256.

## Operation
- FIFO:
  - Push on `in_valid & in_ready`; stores {a, b, op}.
  - `fifo_count` width is log2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
  - A push and a pop on the same edge leave the count unchanged.
  - No push occurs when full, because `in_ready` is 0.
- FSM states IDLE, DRIVE, HOLD:
  - IDLE: if FIFO is non-empty, pop the head into `alu_a/alu_b/alu_op` and go to DRIVE; else stay.
  - DRIVE: lasts exactly one cycle with `alu_*` stable. At its closing edge, capture `alu_result`→`out_result` and `alu_op`→`out_op`, set `out_valid`=1, go to HOLD.
  - HOLD: hold `out_*` stable while `out_valid & ~out_ready`.
    - On handshake: `out_valid`←0 and `op_count`←`op_count`+1.
    - Same edge: if FIFO is non-empty, pop the next command into `alu_*` and go to DRIVE; else go to IDLE.
- `alu_*` retain their last value in IDLE and HOLD; they change only on a pop.
- Results pass through unmodified. With the current logic unit, `out_result[4]` is always 0 and `out_result[3:0]` = a&b (op 0x) or a|b (op 1x). The sequencer does not compute or check results.
- Commands complete strictly in acceptance order; none are dropped or duplicated.

## Timing
- Reset (async assert, sync release):
  - state IDLE, FIFO empty, pointers 0.
  - `alu_a`=`alu_b`=0, `alu_op`=0.
  - `out_valid`=0, `out_result`=0, `out_op`=0, `op_count`=0.
  - `in_ready`=1 (combinational from count) during and after reset.
- Reset mid-operation discards all FIFO contents and any pending output immediately; `out_valid` drops asynchronously.
- Latency from an empty, idle block with a command accepted at edge E:
  - pop at E+1;
  - capture at E+2;
  - `out_valid` high from just after E+2.
- Throughput with `out_ready` held 1 and FIFO non-empty: one result every 2 cycles. `out_valid` is low during each DRIVE cycle.
- Backpressure: `out_ready`=0 holds HOLD indefinitely while the FIFO keeps filling. `in_ready` falls the cycle after the DEPTH-th unpopped push.
- Full FIFO with a pop in HOLD at edge P: `in_ready` rises after P, so a push is accepted no earlier than edge P+1.
- `in_ready` does not depend on `in_valid`, and `out_valid` does not depend on `out_ready` (no combinational loops).
- `op_count` wraps 255→0 on the 256th handshake.

## Test plan
- Reset check: drive `rst`=1 mid-stream with 3 commands queued → all outputs at reset values; after release, no `out_valid` until a new command; `op_count`=0.
- Single op: push a=0xC, b=0xA, op=00 at edge E, `out_ready`=1 → `out_valid` from E+2, `out_result`=0x08, `out_op`=00, `op_count`=1.
- Ordering/throughput: push 4 back-to-back, `out_ready`=1: (0xF,0x3,00), (0xF,0x3,10), (0x5,0xA,01), (0x5,0xA,11) → outputs 0x03, 0x0F, 0x00, 0x0F in order, spaced 2 cycles apart.
- Full/backpressure (DEPTH=4): `out_ready`=0, push 6 commands → first captured, 4 buffered, `in_ready`=0. The 6th is held until `out_ready`=1, then accepted one cycle after the first pop; all 6 results emerge in order.
- Wrap: 256 completed handshakes → `op_count`=0; 257 → 1. FIFO pointer wrap is exercised by more than 2×DEPTH pushes with no loss.
- Stall stability: hold `out_ready`=0 for 10 cycles in HOLD → `out_result`/`out_op` constant and `out_valid`=1 throughout.

Source files
------------

// File: rtl/logic_op_sequencer.sv
// Command sequencer feeding the 4-bit logic unit: buffers {a, b, op} commands in a FIFO,
// drives them one at a time and hands each captured result downstream.
module logic_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [1:0] in_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [4:0] alu_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_result,
  output logic [1:0] out_op,
  output logic [7:0] op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [3:0]    r_memA  [DEPTH];
  logic [3:0]    r_memB  [DEPTH];
  logic [1:0]    r_memOp [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic [3:0] r_aluA;
  logic [3:0] r_aluB;
  logic [1:0] r_aluOp;
  logic       r_outValid;
  logic [4:0] r_outResult;
  logic [1:0] r_outOp;
  logic [7:0] r_opCount;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_capture;
  logic w_handshake;

  // Ready comes from the registered count only, so it never depends on in_valid.
  assign in_ready = (r_count < CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid & in_ready;

  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_op     = r_aluOp;
  assign out_valid  = r_outValid;
  assign out_result = r_outResult;
  assign out_op     = r_outOp;
  assign op_count   = r_opCount;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_stateNext = DRIVE;
        end
      end
      DRIVE: begin
        w_capture   = 1'b1;
        w_stateNext = HOLD;
      end
      HOLD: begin
        if (r_outValid && out_ready) begin
          w_handshake = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_stateNext = DRIVE;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Storage needs no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memA[r_wrPtr]  <= in_a;
      r_memB[r_wrPtr]  <= in_b;
      r_memOp[r_wrPtr] <= in_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluA  <= '0;
      r_aluB  <= '0;
      r_aluOp <= '0;
    end else if (w_pop) begin
      r_aluA  <= r_memA[r_rdPtr];
      r_aluB  <= r_memB[r_rdPtr];
      r_aluOp <= r_memOp[r_rdPtr];
    end
  end

  // Capture closes the DRIVE cycle; the handshake in HOLD retires the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_outResult <= '0;
      r_outOp     <= '0;
      r_opCount   <= '0;
    end else begin
      if (w_capture) begin
        r_outValid  <= 1'b1;
        r_outResult <= alu_result;
        r_outOp     <= r_aluOp;
      end else if (w_handshake) begin
        r_outValid <= 1'b0;
        r_opCount  <= r_opCount + 8'd1;
      end
    end
  end

endmodule
